binary2ascii_6d: RTL and testbench
==================================

# binary2ascii_6d

Sequential binary-to-ASCII converter. Turns a 20-bit unsigned value into six ASCII decimal digits using iterative shift-and-add-3 (double dabble). It sits on the status/report path so axis positions and feed values can go back out over the serial link. Its digit packing is the exact inverse of the 6-digit ASCII input parser: digit0 (units) in [7:0] and digit5 (hundred-thousands) in [47:40].

## Interface
Parameters: none; widths are fixed (20-bit in, 6 digits out).

Ports (all outputs registered):
- i_Clock50MHz  input  1  system clock, 50 MHz, rising edge
- i_Reset_n  input  1  synchronous active-low reset, sampled on i_Clock50MHz rising edge
- i_Start  input  1  conversion request; sampled only in IDLE
- i_BinaryValue  input  20  unsigned value; captured on the accepting edge
- o_Busy  output  1  high while a conversion is in progress (SHIFT or FORMAT)
- o_Done  output  1  one-cycle pulse; o_AsciiValue and o_Overflow are valid from this cycle
- o_AsciiValue  output  48  six ASCII digits; [8k+7:8k] = digit k, k=0 is units
- o_Overflow  output  1  input exceeded 999999; result saturated

## Operation
- Reset (i_Reset_n=0 at an edge):
  - State goes to IDLE, from any state.
  - o_Busy=0, o_Done=0, o_Overflow=0.
  - o_AsciiValue = 48'h303030303030 ("000000"); with the macro defined, 48'h000000000030.
  - Shift and counter registers are cleared.
- IDLE:
  - On i_Start=1, capture i_BinaryValue into a 20-bit shift register.
  - Clear the 24-bit BCD register and the 5-bit counter.
  - Latch overflow = (i_BinaryValue > 999999). If set, substitute 999999 for the captured value.
  - Go to SHIFT.
- SHIFT: one bit per cycle, 20 cycles.
  - In each BCD nibble ≥5, add 3 first.
  - Then shift {BCD, binary} left by one.
  - The counter increments; after the 20th shift, go to FORMAT.
- FORMAT: one cycle.
  - o_AsciiValue digit k = 8'h30 + BCD nibble k.
  - o_Overflow is updated, o_Done is set to 1, and the state returns to IDLE.
- o_Done clears on the next edge. o_AsciiValue and o_Overflow then hold until the next FORMAT or a reset.
- i_Start is ignored while o_Busy=1. It is not queued.
- Changes on i_BinaryValue after capture have no effect on the conversion in flight.
- Arithmetic:
  - BCD nibbles never exceed 9 after the final shift.
  - Each ASCII byte is in 8'h30..8'h39, except for blanked digits (see Configuration).

## Timing
- Start sampled at edge k:
  - o_Busy=1 after edges k+1..k+20 (SHIFT), and after edge k+21 the state is IDLE with o_Busy=0.
  - Precisely: o_Busy is high in the cycles following edges k through k+20.
  - Outputs update and o_Done=1 in the cycle following edge k+21.
- Latency is 21 cycles from the accepting edge to o_Done, i.e. 420 ns at 50 MHz.
- Back-to-back: a new i_Start is accepted at edge k+22, concurrent with the o_Done pulse, giving 22-cycle throughput.
- Reset mid-conversion: the conversion is aborted, no o_Done is issued, and outputs return to reset values at the reset edge.
- Reset and i_Start at the same edge: reset wins and the start is dropped.

## Configuration
- BINARY2ASCII_LZ_BLANK_EN defined:
  - In FORMAT, leading zero digits (from digit5 downward until the first nonzero digit) are emitted as 8'h00 (NUL).
  - digit0 is never blanked; a value of 0 gives 48'h000000000030.
  - This matches the input parser convention that NUL reads as '0'.
- Undefined: all six digits are always emitted as ASCII, zero-padded.

## Test plan
- Reset, then 123456 with i_Start pulse → o_Done exactly 21 cycles after the accepting edge; o_AsciiValue=48'h313233343536; o_Overflow=0; o_Busy low in the Done cycle.
- 0, then 999999 back-to-back (second start during the first o_Done) → 48'h303030303030 (or 48'h000000000030 with the macro), then 48'h393939393939; both with o_Overflow=0; second done 22 cycles after the first.
- 1000000 and 20'hFFFFF → o_AsciiValue=48'h393939393939 and o_Overflow=1; next conversion of 42 → o_Overflow=0 and 48'h303030303432 (48'h000000003432 with the macro).
- Start 500, then pulse i_Start with 777 at edge k+5 while busy → single o_Done at k+21 with 48'h303030353030; no second o_Done; i_BinaryValue toggling mid-conversion has no effect.
- Start 314159, assert i_Reset_n=0 at edge k+10 → no o_Done; outputs at reset values the next cycle; a fresh start of 314159 after release → 48'h333134313539.
- Macro on: 7 → 48'h000000000037; 100000 → 48'h313030303030 (no blanking of interior zeros).

Source files
------------

// File: rtl/binary2ascii_6d.sv
// binary2ascii_6d: 20-bit unsigned to six ASCII decimal digits by iterative double dabble.
// Define BINARY2ASCII_LZ_BLANK_EN to emit leading zero digits (never digit0) as NUL.
module binary2ascii_6d (
    input  logic        i_Clock50MHz,
    input  logic        i_Reset_n,
    input  logic        i_Start,
    input  logic [19:0] i_BinaryValue,
    output logic        o_Busy,
    output logic        o_Done,
    output logic [47:0] o_AsciiValue,
    output logic        o_Overflow
);
`ifdef BINARY2ASCII_LZ_BLANK_EN
    localparam logic [47:0] ASCII_RST = 48'h000000000030;
`else
    localparam logic [47:0] ASCII_RST = 48'h303030303030;
`endif
    localparam logic [19:0] MAX_VAL = 20'd999999;
    typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;
    state_t      state;
    logic [19:0] bin_sr;
    logic [23:0] bcd, bcd_adj;
    logic [4:0]  cnt;
    logic        ovf;
    logic [47:0] ascii;
    logic        lead;
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 6; i++)
            bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    // lead stays high while every digit from digit5 down to the current one is zero
    always_comb begin
        ascii = '0;
        lead  = 1'b1;
        for (int i = 5; i >= 0; i--) begin
`ifdef BINARY2ASCII_LZ_BLANK_EN
            lead = lead && (bcd[4*i +: 4] == 4'd0) && (i != 0);
`else
            lead = 1'b0;
`endif
            ascii[8*i +: 8] = lead ? 8'h00 : {4'h3, bcd[4*i +: 4]};
        end
    end
    always_ff @(posedge i_Clock50MHz) begin
        if (!i_Reset_n) begin
            state        <= IDLE;
            bin_sr       <= '0;
            bcd          <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            o_Busy       <= 1'b0;
            o_Done       <= 1'b0;
            o_AsciiValue <= ASCII_RST;
            o_Overflow   <= 1'b0;
        end else begin
            o_Done <= 1'b0;
            case (state)
                IDLE: if (i_Start) begin
                    ovf    <= i_BinaryValue > MAX_VAL;
                    bin_sr <= (i_BinaryValue > MAX_VAL) ? MAX_VAL : i_BinaryValue;
                    bcd    <= '0;
                    cnt    <= '0;
                    o_Busy <= 1'b1;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    {bcd, bin_sr} <= {bcd_adj[22:0], bin_sr, 1'b0};
                    cnt           <= cnt + 5'd1;
                    if (cnt == 5'd19) state <= FORMAT;
                end
                default: begin
                    o_AsciiValue <= ascii;
                    o_Overflow   <= ovf;
                    o_Done       <= 1'b1;
                    o_Busy       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_binary2ascii_6d.sv
// tb_binary2ascii_6d: directed self-checking bench for binary2ascii_6d.
// Expected ASCII images follow BINARY2ASCII_LZ_BLANK_EN when it is defined.
module tb_binary2ascii_6d;
    logic        i_Clock50MHz = 1'b0;
    logic        i_Reset_n = 1'b0;
    logic        i_Start = 1'b0;
    logic [19:0] i_BinaryValue = '0;
    logic        o_Busy, o_Done, o_Overflow;
    logic [47:0] o_AsciiValue;
    int          cmp = 0;
    int          errs = 0;
`ifdef BINARY2ASCII_LZ_BLANK_EN
    localparam logic [47:0] A_0 = 48'h000000000030;
    localparam logic [47:0] A_42 = 48'h000000003432;
    localparam logic [47:0] A_500 = 48'h000000353030;
    localparam logic [47:0] A_7 = 48'h000000000037;
`else
    localparam logic [47:0] A_0 = 48'h303030303030;
    localparam logic [47:0] A_42 = 48'h303030303432;
    localparam logic [47:0] A_500 = 48'h303030353030;
    localparam logic [47:0] A_7 = 48'h303030303037;
`endif
    binary2ascii_6d dut (
        .i_Clock50MHz (i_Clock50MHz),
        .i_Reset_n    (i_Reset_n),
        .i_Start      (i_Start),
        .i_BinaryValue(i_BinaryValue),
        .o_Busy       (o_Busy),
        .o_Done       (o_Done),
        .o_AsciiValue (o_AsciiValue),
        .o_Overflow   (o_Overflow)
    );
    always #10 i_Clock50MHz = ~i_Clock50MHz;
    task automatic tick();
        @(posedge i_Clock50MHz);
        #1;
    endtask
    // drive a one-cycle start; returns just after the accepting edge
    task automatic start(input logic [19:0] v);
        i_Start = 1'b1;
        i_BinaryValue = v;
        tick();
        i_Start = 1'b0;
    endtask
    task automatic wait_done(output int n);
        n = 0;
        while (!o_Done && n < 60) begin
            tick();
            n++;
        end
    endtask
    task automatic test_reset();
        int nd;
        i_Reset_n = 1'b0;
        tick();
        tick();
        cmp++; if (o_Busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", o_Busy); end
        cmp++; if (o_Done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", o_Done); end
        cmp++; if (o_Overflow !== 1'b0) begin errs++; $display("FAIL reset_ovf got %b want 0", o_Overflow); end
        cmp++; if (o_AsciiValue !== A_0) begin errs++; $display("FAIL reset_ascii got %h want %h", o_AsciiValue, A_0); end
        i_Start = 1'b1;
        i_BinaryValue = 20'd55;
        tick();
        i_Start = 1'b0;
        i_Reset_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            nd += int'(o_Done) + int'(o_Busy);
        end
        cmp++; if (nd !== 0) begin errs++; $display("FAIL reset_start_drop got %0d want 0", nd); end
    endtask
    task automatic test_basic();
        int n;
        start(20'd123456);
        cmp++; if (o_Busy !== 1'b1) begin errs++; $display("FAIL basic_busy got %b want 1", o_Busy); end
        wait_done(n);
        cmp++; if (n !== 21) begin errs++; $display("FAIL basic_latency got %0d want 21", n); end
        cmp++; if (o_AsciiValue !== 48'h313233343536) begin errs++; $display("FAIL basic_ascii got %h want 313233343536", o_AsciiValue); end
        cmp++; if (o_Overflow !== 1'b0) begin errs++; $display("FAIL basic_ovf got %b want 0", o_Overflow); end
        cmp++; if (o_Busy !== 1'b0) begin errs++; $display("FAIL basic_busy_done got %b want 0", o_Busy); end
        tick();
        cmp++; if (o_Done !== 1'b0) begin errs++; $display("FAIL basic_done_pulse got %b want 0", o_Done); end
        cmp++; if (o_AsciiValue !== 48'h313233343536) begin errs++; $display("FAIL basic_hold got %h want 313233343536", o_AsciiValue); end
    endtask
    task automatic test_back_to_back();
        int n;
        start(20'd0);
        wait_done(n);
        cmp++; if (o_AsciiValue !== A_0) begin errs++; $display("FAIL b2b_zero got %h want %h", o_AsciiValue, A_0); end
        cmp++; if (o_Overflow !== 1'b0) begin errs++; $display("FAIL b2b_zero_ovf got %b want 0", o_Overflow); end
        start(20'd999999);
        wait_done(n);
        cmp++; if (n + 1 !== 22) begin errs++; $display("FAIL b2b_spacing got %0d want 22", n + 1); end
        cmp++; if (o_AsciiValue !== 48'h393939393939) begin errs++; $display("FAIL b2b_max got %h want 393939393939", o_AsciiValue); end
        cmp++; if (o_Overflow !== 1'b0) begin errs++; $display("FAIL b2b_max_ovf got %b want 0", o_Overflow); end
        tick();
    endtask
    task automatic test_overflow();
        int n;
        start(20'd1000000);
        wait_done(n);
        cmp++; if (o_AsciiValue !== 48'h393939393939) begin errs++; $display("FAIL ovf_1m got %h want 393939393939", o_AsciiValue); end
        cmp++; if (o_Overflow !== 1'b1) begin errs++; $display("FAIL ovf_1m_flag got %b want 1", o_Overflow); end
        tick();
        start(20'hFFFFF);
        wait_done(n);
        cmp++; if (o_AsciiValue !== 48'h393939393939) begin errs++; $display("FAIL ovf_fffff got %h want 393939393939", o_AsciiValue); end
        cmp++; if (o_Overflow !== 1'b1) begin errs++; $display("FAIL ovf_fffff_flag got %b want 1", o_Overflow); end
        tick();
        start(20'd42);
        wait_done(n);
        cmp++; if (o_AsciiValue !== A_42) begin errs++; $display("FAIL ovf_42 got %h want %h", o_AsciiValue, A_42); end
        cmp++; if (o_Overflow !== 1'b0) begin errs++; $display("FAIL ovf_42_flag got %b want 0", o_Overflow); end
        tick();
    endtask
    task automatic test_ignore_start();
        int n, nd;
        start(20'd500);
        for (int i = 0; i < 4; i++) tick();
        start(20'd777);
        for (int i = 0; i < 5; i++) begin
            i_BinaryValue = 20'hABCDE ^ 20'(i * 20'h1111);
            tick();
        end
        wait_done(n);
        cmp++; if (n + 10 !== 21) begin errs++; $display("FAIL ign_latency got %0d want 21", n + 10); end
        cmp++; if (o_AsciiValue !== A_500) begin errs++; $display("FAIL ign_ascii got %h want %h", o_AsciiValue, A_500); end
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            nd += int'(o_Done);
        end
        cmp++; if (nd !== 0) begin errs++; $display("FAIL ign_second_done got %0d want 0", nd); end
    endtask
    task automatic test_reset_mid();
        int n, nd;
        start(20'd1000000);
        wait_done(n);
        tick();
        start(20'd314159);
        for (int i = 0; i < 9; i++) tick();
        i_Reset_n = 1'b0;
        tick();
        cmp++; if (o_Busy !== 1'b0) begin errs++; $display("FAIL rmid_busy got %b want 0", o_Busy); end
        cmp++; if (o_Overflow !== 1'b0) begin errs++; $display("FAIL rmid_ovf got %b want 0", o_Overflow); end
        cmp++; if (o_AsciiValue !== A_0) begin errs++; $display("FAIL rmid_ascii got %h want %h", o_AsciiValue, A_0); end
        i_Reset_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            nd += int'(o_Done);
        end
        cmp++; if (nd !== 0) begin errs++; $display("FAIL rmid_no_done got %0d want 0", nd); end
        start(20'd314159);
        wait_done(n);
        cmp++; if (o_AsciiValue !== 48'h333134313539) begin errs++; $display("FAIL rmid_fresh got %h want 333134313539", o_AsciiValue); end
        tick();
    endtask
    task automatic test_blanking();
        int n;
        start(20'd7);
        wait_done(n);
        cmp++; if (o_AsciiValue !== A_7) begin errs++; $display("FAIL blank_7 got %h want %h", o_AsciiValue, A_7); end
        tick();
        start(20'd100000);
        wait_done(n);
        cmp++; if (o_AsciiValue !== 48'h313030303030) begin errs++; $display("FAIL blank_100000 got %h want 313030303030", o_AsciiValue); end
        tick();
    endtask
    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_ignore_start();
        test_reset_mid();
        test_blanking();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
